// File: rtl/dsp_seq_controller_pkg.sv
// Shared definitions for the DSP sequencer: DSP mode field widths, the repeat field width,
// the FSM state encoding and the instruction-word width helper.
package dsp_seq_controller_pkg;

  localparam int ALUMODE_WIDTH = 4;
  localparam int OPMODE_WIDTH  = 7;
  localparam int INMODE_WIDTH  = 5;
  localparam int REP_WIDTH     = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_EXECUTE = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  // Instruction layout, LSB first: bram0_r_addr, bram1_r_addr, bram1_w_addr, inmode, opmode, alumode, exec.
  function automatic int ctrl_width(input int addr_width);
    return 1 + ALUMODE_WIDTH + OPMODE_WIDTH + INMODE_WIDTH + 3 * addr_width;
  endfunction

endpackage

// File: rtl/dsp_seq_controller_prog_mem.sv
// Program buffer: DEPTH x WIDTH register file, one write port, registered read port.
// The read register is the instruction register of the sequencer, so a fetch takes one cycle.
module seq_prog_mem #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 36
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     re_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  always_ff @(posedge clk_i) begin
    if (we_i) r_mem[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)   r_rdata <= '0;
    else if (re_i) r_rdata <= r_mem[raddr_i];
  end

  assign rdata_o = r_rdata;

endmodule

// File: rtl/dsp_seq_controller.sv
// Program sequencer for the DSP48 + BRAM datapath: runs up to PROG_DEPTH instructions with repeat counts.
// Optional abort input and early return to IDLE are enabled by defining SEQ_ABORT_EN.
module dsp_seq_controller
  import dsp_seq_controller_pkg::*;
#(
  parameter int ADDR_WIDTH  = 5,
  parameter int PROG_DEPTH  = 8,
  parameter int EXEC_CYCLES = 11
) (
  input  logic                                       clk_i,
  input  logic                                       rst_ni,
  input  logic                                       start_i,
`ifdef SEQ_ABORT_EN
  input  logic                                       abort_i,
`endif
  input  logic                                       prog_we_i,
  input  logic [$clog2(PROG_DEPTH)-1:0]              prog_addr_i,
  input  logic [ctrl_width(ADDR_WIDTH)+REP_WIDTH-1:0] prog_data_i,
  input  logic [$clog2(PROG_DEPTH):0]                prog_len_i,
  output logic                                       busy_o,
  output logic                                       valid_o,
  output logic [$clog2(PROG_DEPTH)-1:0]              pc_o,
  output logic                                       bram1_web_o,
  output logic                                       bram1_reb_o,
  output logic                                       bram0_reb_o,
  output logic [ALUMODE_WIDTH-1:0]                   alumode_o,
  output logic [OPMODE_WIDTH-1:0]                    opmode_o,
  output logic [INMODE_WIDTH-1:0]                    inmode_o,
  output logic [ADDR_WIDTH-1:0]                      bram1_w_addr_o,
  output logic [ADDR_WIDTH-1:0]                      bram1_r_addr_o,
  output logic [ADDR_WIDTH-1:0]                      bram0_r_addr_o
);

  localparam int PC_W    = $clog2(PROG_DEPTH);
  localparam int LEN_W   = PC_W + 1;
  localparam int I_WIDTH = ctrl_width(ADDR_WIDTH);
  localparam int D_W     = I_WIDTH + REP_WIDTH;
  localparam int EC_W    = $clog2(EXEC_CYCLES);

  localparam int B0R_LSB  = 0;
  localparam int B1R_LSB  = ADDR_WIDTH;
  localparam int B1W_LSB  = 2 * ADDR_WIDTH;
  localparam int IN_LSB   = 3 * ADDR_WIDTH;
  localparam int OP_LSB   = IN_LSB + INMODE_WIDTH;
  localparam int ALU_LSB  = OP_LSB + OPMODE_WIDTH;
  localparam int EXEC_BIT = ALU_LSB + ALUMODE_WIDTH;
  localparam int REP_LSB  = I_WIDTH;

  localparam logic [EC_W-1:0]  EC_LAST = EC_W'(EXEC_CYCLES - 1);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PROG_DEPTH);

  state_t                   r_state, w_state_nxt;
  logic [D_W-1:0]           w_ir;
  logic [REP_WIDTH-1:0]     r_rep;
  logic [EC_W-1:0]          r_ec;
  logic [PC_W-1:0]          r_pc;
  logic [LEN_W-1:0]         r_len;
  logic [LEN_W-1:0]         w_len_clip;
  logic                     w_ec_last, w_pc_last, w_busy, w_valid, w_abort;
  logic                     w_mem_we, w_fetch;

  logic                     r_bram1_web, r_bram1_reb, r_bram0_reb;
  logic [ALUMODE_WIDTH-1:0] r_alumode;
  logic [OPMODE_WIDTH-1:0]  r_opmode;
  logic [INMODE_WIDTH-1:0]  r_inmode;
  logic [ADDR_WIDTH-1:0]    r_bram1_w_addr, r_bram1_r_addr, r_bram0_r_addr;

  assign w_len_clip = (prog_len_i > LEN_MAX) ? LEN_MAX : prog_len_i;
  assign w_ec_last  = (r_ec == EC_LAST);
  assign w_pc_last  = ({1'b0, r_pc} == (r_len - LEN_W'(1)));
  assign w_mem_we   = prog_we_i & ~w_busy;
  assign w_fetch    = (r_state == ST_FETCH);

`ifdef SEQ_ABORT_EN
  assign w_abort = abort_i & w_busy;
`else
  assign w_abort = 1'b0;
`endif

  seq_prog_mem #(
    .DEPTH (PROG_DEPTH),
    .WIDTH (D_W)
  ) u_prog_mem (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .we_i    (w_mem_we),
    .waddr_i (prog_addr_i),
    .wdata_i (prog_data_i),
    .re_i    (w_fetch),
    .raddr_i (r_pc),
    .rdata_o (w_ir)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:    if (start_i) w_state_nxt = (w_len_clip == '0) ? ST_DONE : ST_FETCH;
      ST_FETCH:   w_state_nxt = ST_DECODE;
      ST_DECODE:  w_state_nxt = ST_EXECUTE;
      ST_EXECUTE: if (w_ec_last && r_rep == '0) w_state_nxt = w_pc_last ? ST_DONE : ST_FETCH;
      ST_DONE:    if (!start_i) w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
    // Abort outranks normal completion of the final EXECUTE cycle.
    if (w_abort) w_state_nxt = ST_IDLE;
  end

  always_comb begin
    w_busy  = 1'b1;
    w_valid = 1'b0;
    unique case (r_state)
      ST_IDLE: w_busy = 1'b0;
      ST_DONE: begin
        w_busy  = 1'b0;
        w_valid = 1'b1;
      end
      default: w_busy = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pc           <= '0;
      r_ec           <= '0;
      r_rep          <= '0;
      r_len          <= '0;
      r_bram1_web    <= 1'b0;
      r_bram1_reb    <= 1'b0;
      r_bram0_reb    <= 1'b0;
      r_alumode      <= '0;
      r_opmode       <= '0;
      r_inmode       <= '0;
      r_bram1_w_addr <= '0;
      r_bram1_r_addr <= '0;
      r_bram0_r_addr <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          r_pc <= '0;
          r_ec <= '0;
          if (start_i) r_len <= w_len_clip;
        end
        ST_DECODE: begin
          r_bram1_web    <= w_ir[EXEC_BIT];
          r_bram1_reb    <= w_ir[EXEC_BIT];
          r_bram0_reb    <= w_ir[EXEC_BIT];
          r_alumode      <= w_ir[ALU_LSB +: ALUMODE_WIDTH];
          r_opmode       <= w_ir[OP_LSB +: OPMODE_WIDTH];
          r_inmode       <= w_ir[IN_LSB +: INMODE_WIDTH];
          r_bram1_w_addr <= w_ir[B1W_LSB +: ADDR_WIDTH];
          r_bram1_r_addr <= w_ir[B1R_LSB +: ADDR_WIDTH];
          r_bram0_r_addr <= w_ir[B0R_LSB +: ADDR_WIDTH];
          r_rep          <= w_ir[REP_LSB +: REP_WIDTH];
          r_ec           <= '0;
        end
        ST_EXECUTE: begin
          if (w_ec_last) begin
            if (r_rep != '0) begin
              // Next repetition: step all addresses and re-arm the one-cycle write pulse.
              r_rep          <= r_rep - REP_WIDTH'(1);
              r_bram1_w_addr <= r_bram1_w_addr + ADDR_WIDTH'(1);
              r_bram1_r_addr <= r_bram1_r_addr + ADDR_WIDTH'(1);
              r_bram0_r_addr <= r_bram0_r_addr + ADDR_WIDTH'(1);
              r_bram1_web    <= w_ir[EXEC_BIT];
              r_ec           <= '0;
            end else begin
              r_bram1_web <= 1'b0;
              if (!w_pc_last) r_pc <= r_pc + PC_W'(1);
            end
          end else begin
            r_ec        <= r_ec + EC_W'(1);
            r_bram1_web <= 1'b0;
          end
        end
        default: ;
      endcase
      if (w_abort) r_bram1_web <= 1'b0;
    end
  end

  assign busy_o         = w_busy;
  assign valid_o        = w_valid;
  assign pc_o           = r_pc;
  assign bram1_web_o    = r_bram1_web;
  assign bram1_reb_o    = r_bram1_reb;
  assign bram0_reb_o    = r_bram0_reb;
  assign alumode_o      = r_alumode;
  assign opmode_o       = r_opmode;
  assign inmode_o       = r_inmode;
  assign bram1_w_addr_o = r_bram1_w_addr;
  assign bram1_r_addr_o = r_bram1_r_addr;
  assign bram0_r_addr_o = r_bram0_r_addr;

endmodule

// File: doc/dsp_seq_controller.md
# dsp_seq_controller

Parametrised successor to the single-instruction DSP controller. Runs a program of up to PROG_DEPTH instructions from an internal program buffer, with per-instruction repeat counts and automatic BRAM address stepping. Sits between the host/start logic and the DSP48 + BRAM0/BRAM1 datapath and drives the same mode, enable and address lines. Raises valid_o once the whole program has finished.

## Interface
- ADDR_WIDTH, 5: BRAM address width.
- PROG_DEPTH, 8: program buffer entries (power of two, ≥2).
- EXEC_CYCLES, 11: cycles per execution of one instruction (≥2).
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- start_i  in  1  run request; level, held until valid_o is seen.
- prog_we_i  in  1  program buffer write strobe.
- prog_addr_i  in  $clog2(PROG_DEPTH)  write index.
- prog_data_i  in  `I_WIDTH+4  instruction word plus 4-bit repeat count in the MSBs (`REPEAT field).
- prog_len_i  in  $clog2(PROG_DEPTH)+1  number of instructions to run; sampled at start.
- abort_i  in  1  only with SEQ_ABORT_EN.
- busy_o  out  1  high in every state except IDLE and DONE.
- valid_o  out  1  program complete.
- pc_o  out  $clog2(PROG_DEPTH)  current instruction index.
- bram1_web_o, bram1_reb_o, bram0_reb_o  out  1 each  BRAM enables.
- alumode_o  out  `ALUMODE_WIDTH; opmode_o  out  `OPMODE_WIDTH; inmode_o  out  `INMODE_WIDTH: DSP mode fields.
- bram1_w_addr_o, bram1_r_addr_o, bram0_r_addr_o  out  ADDR_WIDTH each: BRAM addresses.

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, DONE.
- IDLE:
  - pc ← 0; ec ← 0.
  - If start_i=1, latch len = min(prog_len_i, PROG_DEPTH).
  - If len=0, go to DONE; otherwise go to FETCH.
- FETCH: ir ← prog_mem[pc]. Go to DECODE.
- DECODE:
  - Load every output field from ir: `EXEC drives all three enables; `ALUMODE, `OPMODE and `INMODE drive the mode outputs; the three address fields drive the addresses.
  - rep ← ir[`REPEAT]; ec ← 0. Go to EXECUTE.
- EXECUTE: ec increments each cycle. bram1_web_o is forced to 0 from the second EXECUTE cycle of each repetition, so each repetition produces a single-cycle write pulse.
- When ec = EXEC_CYCLES−1:
  - If rep≠0: rep−1; all three addresses +1 modulo 2^ADDR_WIDTH; bram1_web_o ← ir[`EXEC]; ec ← 0; stay in EXECUTE.
  - Else if pc = len−1: go to DONE.
  - Else: pc+1; go to FETCH.
- DONE: valid_o=1. Stay until start_i=0, then go to IDLE.
- Program writes are accepted only when busy_o=0. A write while busy_o=1 is silently dropped.
- Other outputs keep their last decoded values outside DECODE and EXECUTE.

## Timing
- Reset: state IDLE; pc, ec, rep, ir, every output and valid_o are 0. The program buffer is not reset.
- All outputs are registered. valid_o and busy_o are decoded from the state register.
- Per instruction i: 2 + (r_i+1)·EXEC_CYCLES cycles.
- valid_o rises 1 + Σ_i(2 + (r_i+1)·EXEC_CYCLES) cycles after the edge that samples start_i=1 in IDLE.
- len=0: valid_o high 1 cycle after start.
- start_i low during a run is ignored. The run always completes.
- start_i still high in DONE: remain in DONE. No auto-restart.
- A program write and FETCH can never coincide, because writes are gated by busy_o.
- Reset asserted mid-run: immediate return to the reset values above.

## Configuration
- SEQ_ABORT_EN defined:
  - abort_i=1 in FETCH, DECODE or EXECUTE → next state IDLE, bram1_web_o ← 0, valid_o stays 0.
  - abort_i has priority over normal EXECUTE completion in the same cycle.
  - abort_i is ignored in IDLE and DONE.
- SEQ_ABORT_EN undefined: no abort_i port, and the run always completes.

## Structure
- Shared def.v holds:
  - existing field macros (`EXEC, `ALUMODE, `OPMODE, `INMODE, `BRAM1_W_ADDR, `BRAM1_R_ADDR, `BRAM0_R_ADDR, widths);
  - the new `REPEAT field macro and `REP_WIDTH (4);
  - the state encodings.
- One sub-module, seq_prog_mem: PROG_DEPTH × (`I_WIDTH+4) synchronous-read register file with write port and registered read. It feeds ir, so FETCH is exactly one cycle.

## Test plan
- Reset: hold rst_ni=0 with random inputs → every output 0, busy_o=0, valid_o=0; release → still IDLE.
- One instruction, rep=0, EXEC_CYCLES=11, write addr 3 → valid_o at cycle 14; bram1_web_o high exactly 1 cycle; bram1_w_addr_o=3.
- rep=2, bram0_r_addr=30 → addresses go 30, 31, 0 across repetitions; three web pulses; valid_o at cycle 1+2+33=36.
- Three-instruction program, prog_len_i=3 → pc_o steps 0, 1, 2; each DECODE loads its own fields; valid_o held while start_i=1, drops the cycle after start_i=0.
- prog_we_i during EXECUTE → entry unchanged on re-run; prog_len_i=0 → valid_o 1 cycle after start.
- SEQ_ABORT_EN: abort_i in 5th EXECUTE cycle → IDLE next cycle, web 0, valid_o never asserted; fresh start then runs normally.
